vga_capture: RTL
================

Name: vga_capture

Overview:
- Receive side of the team's pixel-clock video interface: consumes hsync/vsync/de/RGB as produced by the display timing generator and recovers pixel coordinates.
- Verifies frame geometry and locks onto the stream.
- When locked and armed, writes each active pixel into a frame buffer through a simple write port.
- Used for loopback self-test of the display path and as the front end of the frame-grab path.

Parameters:
R_WIDTH, 5, red field width
G_WIDTH, 6, green field width
B_WIDTH, 5, blue field width
H_ACTIVE, 640, expected de-high pixels per line
V_ACTIVE, 480, expected active lines per frame
X_WIDTH, 10, x coordinate / line-length counter width
Y_WIDTH, 10, y coordinate / line counter width
ADDR_WIDTH, 19, frame-buffer address width (must hold H_ACTIVE*V_ACTIVE-1)
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
hsync  in  1  horizontal sync, active high
vsync  in  1  vertical sync, active high
de  in  1  data enable, high during active pixels
red  in  R_WIDTH  red sample
green  in  G_WIDTH  green sample
blue  in  B_WIDTH  blue sample
cap_en  in  1  capture request, sampled at frame start
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_WIDTH  write address, y*H_ACTIVE+x
wr_data  out  R+G+B  {red,green,blue}
x  out  X_WIDTH  x of current write
y  out  Y_WIDTH  y of current write
locked  out  1  geometry verified
frame_done  out  1  one-cycle pulse, captured frame complete and good
err  out  1  one-cycle pulse, geometry mismatch
meas_h  out  X_WIDTH  last measured de run length
meas_v  out  Y_WIDTH  last measured active-line count

Behaviour:
- Reset (rst=0, async): all outputs 0, counters 0, state IDLE.
- Stage 1 registers all inputs. Edges are detected from stage 1 versus its delayed copy. All outputs are registered, so wr_* appear 2 clk after the pixel is on the pins. hsync is not used for counting; it is kept for future checks.
- Frame start (FS) = vsync rising edge. Line end (LE) = de falling edge.
- h_cnt increments on each stage-1 de=1 cycle and saturates at all-ones.
- At LE: meas_h <= h_cnt; h_cnt <= 0; v_cnt increments (saturating).
- At FS: meas_v <= v_cnt; v_cnt <= 0.
- A frame is good iff every LE in it saw h_cnt == H_ACTIVE and the FS-time v_cnt == V_ACTIVE. A sticky bad flag is set on any bad LE and cleared at FS.
- FSM states: IDLE, SYNC, LOCKED.
  - IDLE: at the first FS, go to SYNC, good_cnt=0.
  - SYNC: at each FS, if the frame was good, good_cnt++; when good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1. If the frame was bad, good_cnt=0 and err pulses.
  - LOCKED: at FS, if the frame was bad, go to SYNC, locked=0, err pulses, good_cnt=0.
- Capture:
  - At FS while in LOCKED (evaluated after the check, i.e. only if staying LOCKED), armed <= cap_en. cap_en changes mid-frame are ignored.
  - While armed, each de pixel with h_cnt < H_ACTIVE and v_cnt < V_ACTIVE writes once: wr_en=1, wr_data=stage-1 RGB, x=h_cnt, y=v_cnt, wr_addr from a running counter cleared at FS.
  - Pixels beyond H_ACTIVE in a line, or lines beyond V_ACTIVE, are never written, so wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.
  - At the next FS, if armed and the frame was good, frame_done pulses. If bad, err pulses, no frame_done, and armed clears.
- Leaving LOCKED clears armed immediately.
- FS while de=1: counts as a bad frame and ends the line (LE is implied).
- wr_en=0 whenever not writing. x, y, wr_addr and wr_data hold their last values.

Decomposition:
- The shared parameter header holds the colour widths, H/V active/front/pulse/back constants, and FSM state encodings (IDLE=0, SYNC=1, LOCKED=2), so generator and capture agree.
- One sub-module, vga_edge_detect: stage-1 register plus rise/fall pulses for vsync and de.

Test Plan:
- Bench generator with H_ACTIVE=8, V_ACTIVE=4, small porches. Release rst, cap_en=0 → no wr_en; locked rises on the 3rd FS; meas_h=8, meas_v=4.
- Locked, cap_en=1 before FS, pixel colour = {x,y} pattern → exactly 32 writes, wr_addr 0..31 in order, data/x/y match; one frame_done pulse at the next FS.
- One line with 7 de cycles → meas_h=7; err pulse and locked=0 at FS; relock after 2 good frames (locked on the 2nd following FS).
- One line with 9 de cycles while capturing → only 8 writes for that line, the 9th is dropped; err at FS, no frame_done.
- cap_en raised mid-frame → zero writes that frame; writes start at the next FS.
- rst pulsed low mid-line during capture → wr_en and locked drop within the same cycle (async); no writes until relock (3rd FS after release).

Source files
------------

// File: rtl/vga_capture_pkg.sv
// Shared constants for the pixel-clock video path: colour widths, 640x480 timing
// and the capture FSM encoding, so generator and capture agree.
package vga_capture_pkg;

  localparam int VGA_R_WIDTH  = 5;
  localparam int VGA_G_WIDTH  = 6;
  localparam int VGA_B_WIDTH  = 5;
  localparam int VGA_RGB_WIDTH = VGA_R_WIDTH + VGA_G_WIDTH + VGA_B_WIDTH;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_PULSE  = 96;
  localparam int VGA_H_BACK   = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_PULSE  = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_X_WIDTH     = 10;
  localparam int VGA_Y_WIDTH     = 10;
  localparam int VGA_ADDR_WIDTH  = 19;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } cap_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// Stage-1 input register for the capture front end, plus one-cycle edge
// pulses derived from stage 1 against its delayed copy.
module vga_edge_detect
  import vga_capture_pkg::*;
#(
  parameter int D_WIDTH = VGA_RGB_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  input  logic               cap_en,
  input  logic [D_WIDTH-1:0] rgb,
  output logic               hsync_s1,
  output logic               de_s1,
  output logic               cap_en_s1,
  output logic [D_WIDTH-1:0] rgb_s1,
  output logic               vsync_rise,
  output logic               de_rise,
  output logic               de_fall
);

  logic               hsync_r;
  logic               vsync_r;
  logic               de_r;
  logic               cap_en_r;
  logic [D_WIDTH-1:0] rgb_r;
  logic               vsync_d_r;
  logic               de_d_r;

  // stage-1 sample of every input and a delayed copy of the two edge sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      de_r      <= 1'b0;
      cap_en_r  <= 1'b0;
      rgb_r     <= {D_WIDTH{1'b0}};
      vsync_d_r <= 1'b0;
      de_d_r    <= 1'b0;
    end else begin
      hsync_r   <= hsync;
      vsync_r   <= vsync;
      de_r      <= de;
      cap_en_r  <= cap_en;
      rgb_r     <= rgb;
      vsync_d_r <= vsync_r;
      de_d_r    <= de_r;
    end
  end

  assign hsync_s1   = hsync_r;
  assign de_s1      = de_r;
  assign cap_en_s1  = cap_en_r;
  assign rgb_s1     = rgb_r;
  assign vsync_rise = vsync_r & ~vsync_d_r;
  assign de_rise    = de_r & ~de_d_r;
  assign de_fall    = ~de_r & de_d_r;

endmodule

// File: rtl/vga_capture.sv
// Receive side of the pixel-clock video interface: measures frame geometry,
// locks after consecutive good frames and writes armed frames to a frame buffer.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int R_WIDTH     = VGA_R_WIDTH,
  parameter int G_WIDTH     = VGA_G_WIDTH,
  parameter int B_WIDTH     = VGA_B_WIDTH,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int X_WIDTH     = VGA_X_WIDTH,
  parameter int Y_WIDTH     = VGA_Y_WIDTH,
  parameter int ADDR_WIDTH  = VGA_ADDR_WIDTH,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               hsync,
  input  logic                               vsync,
  input  logic                               de,
  input  logic [R_WIDTH-1:0]                 red,
  input  logic [G_WIDTH-1:0]                 green,
  input  logic [B_WIDTH-1:0]                 blue,
  input  logic                               cap_en,
  output logic                               wr_en,
  output logic [ADDR_WIDTH-1:0]              wr_addr,
  output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] wr_data,
  output logic [X_WIDTH-1:0]                 x,
  output logic [Y_WIDTH-1:0]                 y,
  output logic                               locked,
  output logic                               frame_done,
  output logic                               err,
  output logic [X_WIDTH-1:0]                 meas_h,
  output logic [Y_WIDTH-1:0]                 meas_v
);

  localparam int D_WIDTH  = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int GC_WIDTH = $clog2(LOCK_FRAMES + 1);

  localparam logic [X_WIDTH-1:0]    H_ACT   = X_WIDTH'(H_ACTIVE);
  localparam logic [Y_WIDTH-1:0]    V_ACT   = Y_WIDTH'(V_ACTIVE);
  localparam logic [X_WIDTH-1:0]    X_ONE   = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]    Y_ONE   = Y_WIDTH'(1);
  localparam logic [X_WIDTH-1:0]    X_MAX   = {X_WIDTH{1'b1}};
  localparam logic [Y_WIDTH-1:0]    Y_MAX   = {Y_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [GC_WIDTH-1:0]   GC_ONE  = GC_WIDTH'(1);
  localparam logic [GC_WIDTH-1:0]   GC_LOCK = GC_WIDTH'(LOCK_FRAMES);

  logic               hsync_s1;
  logic               de_s1;
  logic               cap_en_s1;
  logic [D_WIDTH-1:0] rgb_s1;
  logic               vsync_rise;
  logic               de_rise;
  logic               de_fall;
  logic               unused_s;

  logic               fs_s;
  logic               le_s;
  logic               le_bad_s;
  logic               frame_good_s;
  logic               wr_go_s;
  logic [Y_WIDTH-1:0] v_fs_s;

  logic [X_WIDTH-1:0]    h_cnt_r;
  logic [Y_WIDTH-1:0]    v_cnt_r;
  logic [X_WIDTH-1:0]    meas_h_r;
  logic [Y_WIDTH-1:0]    meas_v_r;
  logic                  bad_r;
  logic [ADDR_WIDTH-1:0] addr_cnt_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [D_WIDTH-1:0]    wr_data_r;
  logic [X_WIDTH-1:0]    x_r;
  logic [Y_WIDTH-1:0]    y_r;

  cap_state_e          state_r;
  cap_state_e          state_nxt_s;
  logic [GC_WIDTH-1:0] good_cnt_r;
  logic [GC_WIDTH-1:0] good_cnt_nxt_s;
  logic                armed_r;
  logic                armed_nxt_s;
  logic                locked_r;
  logic                locked_nxt_s;
  logic                err_r;
  logic                err_nxt_s;
  logic                done_r;
  logic                done_nxt_s;

  vga_edge_detect #(
    .D_WIDTH (D_WIDTH)
  ) u_edge (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .cap_en     (cap_en),
    .rgb        ({red, green, blue}),
    .hsync_s1   (hsync_s1),
    .de_s1      (de_s1),
    .cap_en_s1  (cap_en_s1),
    .rgb_s1     (rgb_s1),
    .vsync_rise (vsync_rise),
    .de_rise    (de_rise),
    .de_fall    (de_fall)
  );

  // hsync and de rise are registered for future checks only
  assign unused_s = hsync_s1 ^ de_rise;

  // A frame start that lands inside active video also closes the open line.
  assign fs_s         = vsync_rise;
  assign le_s         = de_fall | (fs_s & de_s1);
  assign le_bad_s     = le_s & (h_cnt_r != H_ACT);
  assign v_fs_s       = (le_s && (v_cnt_r != Y_MAX)) ? (v_cnt_r + Y_ONE) : v_cnt_r;
  assign frame_good_s = ~bad_r & ~le_bad_s & ~(fs_s & de_s1) & (v_fs_s == V_ACT);

  // line/frame measurement counters and the sticky bad-line flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_r  <= {X_WIDTH{1'b0}};
      v_cnt_r  <= {Y_WIDTH{1'b0}};
      meas_h_r <= {X_WIDTH{1'b0}};
      meas_v_r <= {Y_WIDTH{1'b0}};
      bad_r    <= 1'b0;
    end else begin
      if (le_s) begin
        h_cnt_r  <= {X_WIDTH{1'b0}};
        meas_h_r <= h_cnt_r;
      end else if (de_s1 && (h_cnt_r != X_MAX)) begin
        h_cnt_r <= h_cnt_r + X_ONE;
      end
      if (fs_s) begin
        v_cnt_r  <= {Y_WIDTH{1'b0}};
        meas_v_r <= v_fs_s;
        bad_r    <= 1'b0;
      end else begin
        if (le_s && (v_cnt_r != Y_MAX)) begin
          v_cnt_r <= v_cnt_r + Y_ONE;
        end
        if (le_bad_s) begin
          bad_r <= 1'b1;
        end
      end
    end
  end

  // Only in-window pixels are written, so the address never leaves the frame.
  assign wr_go_s = armed_r & de_s1 & ~fs_s & (h_cnt_r < H_ACT) & (v_cnt_r < V_ACT);

  // frame-buffer write port; address runs from zero at each frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {D_WIDTH{1'b0}};
      x_r        <= {X_WIDTH{1'b0}};
      y_r        <= {Y_WIDTH{1'b0}};
      addr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      wr_en_r <= wr_go_s;
      if (wr_go_s) begin
        wr_addr_r <= addr_cnt_r;
        wr_data_r <= rgb_s1;
        x_r       <= h_cnt_r;
        y_r       <= v_cnt_r;
      end
      if (fs_s) begin
        addr_cnt_r <= {ADDR_WIDTH{1'b0}};
      end else if (wr_go_s) begin
        addr_cnt_r <= addr_cnt_r + A_ONE;
      end
    end
  end

  // lock FSM next state; every decision is taken at frame start only
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt_r;
    armed_nxt_s    = armed_r;
    locked_nxt_s   = locked_r;
    err_nxt_s      = 1'b0;
    done_nxt_s     = 1'b0;
    if (fs_s) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s    = ST_SYNC;
          good_cnt_nxt_s = {GC_WIDTH{1'b0}};
        end
        ST_SYNC: begin
          if (frame_good_s) begin
            good_cnt_nxt_s = good_cnt_r + GC_ONE;
            if ((good_cnt_r + GC_ONE) == GC_LOCK) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_SYNC;
            end
          end else begin
            good_cnt_nxt_s = {GC_WIDTH{1'b0}};
            err_nxt_s      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (frame_good_s) begin
            done_nxt_s  = armed_r;
            armed_nxt_s = cap_en_s1;
          end else begin
            state_nxt_s    = ST_SYNC;
            locked_nxt_s   = 1'b0;
            armed_nxt_s    = 1'b0;
            err_nxt_s      = 1'b1;
            good_cnt_nxt_s = {GC_WIDTH{1'b0}};
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          good_cnt_nxt_s = {GC_WIDTH{1'b0}};
          armed_nxt_s    = 1'b0;
          locked_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // lock FSM state and registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      good_cnt_r <= {GC_WIDTH{1'b0}};
      armed_r    <= 1'b0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      armed_r    <= armed_nxt_s;
      locked_r   <= locked_nxt_s;
      err_r      <= err_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign x          = x_r;
  assign y          = y_r;
  assign locked     = locked_r;
  assign frame_done = done_r;
  assign err        = err_r;
  assign meas_h     = meas_h_r;
  assign meas_v     = meas_v_r;

endmodule
